// File: rtl/video_timing_pattern_gen.sv
// Parametrised raster timing generator with built-in test patterns (bars, solid, grid, gradient).
// Every output is registered one cycle after the counter state it describes.
module video_timing_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = 12
) (
    input  logic          pix_clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [23:0]   solid_rgb,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned BW      = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam int unsigned SW      = (BW > 1) ? $clog2(BW) : 1;

    localparam logic [HW-1:0] HLast      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HActLast   = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HSyncFirst = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HSyncLast  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VLast      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VActLast   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VSyncFirst = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VSyncLast  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [SW-1:0] BarLast    = SW'(BW - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [2:0]    bar_q, bar_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [23:0]   rgb_q, rgb_d;

    logic          h_wrap, v_wrap, at_origin, in_de;
    logic [23:0]   bar_rgb, pat_rgb;

    always_comb begin
        h_wrap    = (h_q == HLast);
        v_wrap    = (v_q == VLast);
        at_origin = (h_q == '0) && (v_q == '0);

        h_d = h_wrap ? '0 : h_q + HW'(1);
        v_d = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + VW'(1);
        end
        frame_cnt_d = (h_wrap && v_wrap) ? frame_cnt_q + 8'd1 : frame_cnt_q;

        // The pixel at (0,0) already uses the freshly sampled mode.
        mode_d = at_origin ? mode : mode_q;

        // sub_q/bar_q always describe the current h_q; bar index saturates at 7.
        sub_d = sub_q;
        bar_d = bar_q;
        if (h_wrap) begin
            sub_d = '0;
            bar_d = 3'd0;
        end else if (sub_q == BarLast) begin
            sub_d = '0;
            bar_d = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end else begin
            sub_d = sub_q + SW'(1);
        end
    end

    always_comb begin
        bar_rgb = 24'h000000;
        unique case (bar_q)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            3'd7: bar_rgb = 24'h000000;
        endcase

        pat_rgb = 24'h000000;
        unique case (mode_d)
            2'd0: pat_rgb = bar_rgb;
            2'd1: pat_rgb = solid_rgb;
            2'd2: pat_rgb = ((5'(h_q) == 5'd0) || (5'(v_q) == 5'd0)) ? 24'hFFFFFF : 24'h000000;
            2'd3: pat_rgb = {8'(h_q), 8'(v_q), frame_cnt_q};
        endcase

        in_de         = (h_q <= HActLast) && (v_q <= VActLast);
        de_d          = in_de;
        hsync_d       = ((h_q >= HSyncFirst) && (h_q <= HSyncLast)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = ((v_q >= VSyncFirst) && (v_q <= VSyncLast)) ? VSYNC_POL : ~VSYNC_POL;
        x_d           = in_de ? CW'(h_q) : '0;
        y_d           = in_de ? CW'(v_q) : '0;
        line_start_d  = (h_q == '0);
        frame_start_d = at_origin;
        rgb_d         = in_de ? pat_rgb : 24'h000000;
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            sub_q         <= '0;
            bar_q         <= 3'd0;
            mode_q        <= 2'd0;
            frame_cnt_q   <= 8'd0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= 24'h000000;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            sub_q         <= sub_d;
            bar_q         <= bar_d;
            mode_q        <= mode_d;
            frame_cnt_q   <= frame_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign r           = rgb_q[23:16];
    assign g           = rgb_q[15:8];
    assign b           = rgb_q[7:0];

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen: three configurations driven in lock-step, checked against a
// pixel-index reference model through per-instance scoreboards plus directed timing checks.
module tb_video_timing_pattern_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic [23:0] rgb;
    } out_t;

    localparam int NCYC   = 41000;
    localparam int RST_AT = 18705;  // instance 1 is at h=300, v=3 of its third frame here

    int   PH[3][4] = '{'{8, 1, 2, 1}, '{640, 16, 96, 48}, '{645, 16, 96, 48}};
    int   PV[3][4] = '{'{4, 1, 1, 1}, '{6, 1, 2, 1}, '{2, 1, 1, 1}};
    bit   PHP[3]   = '{1'b1, 1'b0, 1'b0};
    bit   PVP[3]   = '{1'b1, 1'b0, 1'b0};
    logic [23:0] BARS[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        pix_clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;

    logic        hs_w[3], vs_w[3], de_w[3], ls_w[3], fs_w[3];
    logic [11:0] x_w[3], y_w[3];
    logic [7:0]  r_w[3], g_w[3], b_w[3];

    out_t        sbq[3][$];
    int          tpos[3];
    logic [1:0]  lat[3];
    int          errors = 0;
    int          checks = 0;
    int          mcyc = 0;

    always #5 pix_clk = ~pix_clk;

    video_timing_pattern_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(12)
    ) u_small (
        .pix_clk(pix_clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hs_w[0]), .vsync(vs_w[0]), .de(de_w[0]), .x(x_w[0]), .y(y_w[0]),
        .line_start(ls_w[0]), .frame_start(fs_w[0]), .r(r_w[0]), .g(g_w[0]), .b(b_w[0])
    );

    video_timing_pattern_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(12)
    ) u_vga (
        .pix_clk(pix_clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hs_w[1]), .vsync(vs_w[1]), .de(de_w[1]), .x(x_w[1]), .y(y_w[1]),
        .line_start(ls_w[1]), .frame_start(fs_w[1]), .r(r_w[1]), .g(g_w[1]), .b(b_w[1])
    );

    video_timing_pattern_gen #(
        .H_ACTIVE(645), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(12)
    ) u_wide (
        .pix_clk(pix_clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hs_w[2]), .vsync(vs_w[2]), .de(de_w[2]), .x(x_w[2]), .y(y_w[2]),
        .line_start(ls_w[2]), .frame_start(fs_w[2]), .r(r_w[2]), .g(g_w[2]), .b(b_w[2])
    );

    function automatic int flen(input int d);
        return (PH[d][0] + PH[d][1] + PH[d][2] + PH[d][3]) *
               (PV[d][0] + PV[d][1] + PV[d][2] + PV[d][3]);
    endfunction

    // Output expected for pixel index t since reset release, computed from raster arithmetic.
    function automatic out_t model(input int d, input bit in_rst, input int t,
                                   input logic [1:0] m, input logic [23:0] solid);
        out_t o;
        int ht, vt, h, v, f, bw, idx;
        ht   = PH[d][0] + PH[d][1] + PH[d][2] + PH[d][3];
        vt   = PV[d][0] + PV[d][1] + PV[d][2] + PV[d][3];
        o    = '0;
        o.hs = ~PHP[d];
        o.vs = ~PVP[d];
        if (in_rst) return o;
        h = t % ht;
        v = (t / ht) % vt;
        f = (t / (ht * vt)) % 256;
        if (h >= PH[d][0] + PH[d][1] && h < PH[d][0] + PH[d][1] + PH[d][2]) o.hs = PHP[d];
        if (v >= PV[d][0] + PV[d][1] && v < PV[d][0] + PV[d][1] + PV[d][2]) o.vs = PVP[d];
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        o.de = (h < PH[d][0]) && (v < PV[d][0]);
        if (o.de) begin
            o.x = 12'(h);
            o.y = 12'(v);
            bw  = PH[d][0] / 8;
            if (bw < 1) bw = 1;
            idx = h / bw;
            if (idx > 7) idx = 7;
            case (m)
                2'd0:    o.rgb = BARS[idx];
                2'd1:    o.rgb = solid;
                2'd2:    o.rgb = (h % 32 == 0 || v % 32 == 0) ? 24'hFFFFFF : 24'h000000;
                default: o.rgb = {8'(h % 256), 8'(v % 256), 8'(f)};
            endcase
        end
        return o;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, mcyc);
            if (errors >= 50) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    endtask

    // Driver: inputs change on the falling edge; expected registered output is queued alongside.
    initial begin
        rst       = 1'b1;
        mode      = 2'd3;
        solid_rgb = 24'h0;
        for (int d = 0; d < 3; d++) begin
            tpos[d] = 0;
            lat[d]  = 2'd0;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(negedge pix_clk);
            rst       = (c < 5) || (c >= RST_AT && c < RST_AT + 3);
            solid_rgb = 24'($urandom);
            if (c < 300)              mode = 2'd3;
            else if (c < 12005)       mode = 2'd0;
            else if (c < RST_AT + 3)  mode = 2'd3;
            else if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            for (int d = 0; d < 3; d++) begin
                out_t e;
                if (rst) begin
                    e       = model(d, 1'b1, 0, 2'd0, 24'h0);
                    tpos[d] = 0;
                    lat[d]  = 2'd0;
                end else begin
                    if (tpos[d] % flen(d) == 0) lat[d] = mode;
                    e = model(d, 1'b0, tpos[d], lat[d], solid_rgb);
                    tpos[d]++;
                end
                sbq[d].push_back(e);
            end
        end
        repeat (3) @(posedge pix_clk);
        #2;
        for (int d = 0; d < 3; d++) cmp("sb_drain", 64'(sbq[d].size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Monitor: scoreboard pops plus directed timing and pattern checks.
    int   last_ls1 = -1, hs_fall1 = -1, de_cnt1 = 0;
    int   last_fs0 = -1, vs_rise0 = -1, frames0 = 0;
    logic prev_rst = 1'b0, prev_hs1 = 1'b1, prev_vs0 = 1'b0;

    always @(posedge pix_clk) begin
        #1;
        for (int d = 0; d < 3; d++) begin
            if (sbq[d].size() > 0) begin
                out_t a, e;
                e = sbq[d].pop_front();
                a = '{hs: hs_w[d], vs: vs_w[d], de: de_w[d], x: x_w[d], y: y_w[d],
                      ls: ls_w[d], fs: fs_w[d], rgb: {r_w[d], g_w[d], b_w[d]}};
                cmp($sformatf("pixel_dut%0d", d), 64'(a), 64'(e));
            end
        end
        if (rst) begin
            last_ls1 = -1; hs_fall1 = -1; de_cnt1 = 0;
            last_fs0 = -1; vs_rise0 = -1; frames0 = 0;
        end else begin
            if (prev_rst) cmp("release_fs_de", {61'd0, fs_w[1], de_w[1], fs_w[0]}, 64'h7);
            if (ls_w[1]) begin
                if (last_ls1 >= 0) cmp("line_period", 64'(mcyc - last_ls1), 64'd800);
                if (de_cnt1 != 0)  cmp("de_per_line", 64'(de_cnt1), 64'd640);
                de_cnt1  = 0;
                last_ls1 = mcyc;
            end
            if (de_w[1]) de_cnt1++;
            if (prev_hs1 && !hs_w[1] && last_ls1 >= 0) begin
                cmp("hsync_start", 64'(mcyc - last_ls1), 64'd656);
                hs_fall1 = mcyc;
            end
            if (!prev_hs1 && hs_w[1] && hs_fall1 >= 0) begin
                cmp("hsync_width", 64'(mcyc - hs_fall1), 64'd96);
                hs_fall1 = -1;
            end
            if (fs_w[0]) begin
                frames0++;
                if (last_fs0 >= 0) cmp("frame_period", 64'(mcyc - last_fs0), 64'd84);
                last_fs0 = mcyc;
            end
            if (!prev_vs0 && vs_w[0] && last_fs0 >= 0) begin
                cmp("vsync_start", 64'(mcyc - last_fs0), 64'd60);
                vs_rise0 = mcyc;
            end
            if (prev_vs0 && !vs_w[0] && vs_rise0 >= 0) begin
                cmp("vsync_width", 64'(mcyc - vs_rise0), 64'd12);
                vs_rise0 = -1;
            end
            if (lat[1] == 2'd0 && de_w[1]) begin
                if (x_w[1] == 12'd0 || x_w[1] == 12'd79)
                    cmp("bar_white", 64'({r_w[1], g_w[1], b_w[1]}), 64'hFFFFFF);
                if (x_w[1] == 12'd80)
                    cmp("bar_yellow", 64'({r_w[1], g_w[1], b_w[1]}), 64'hFFFF00);
                if (x_w[1] == 12'd639)
                    cmp("bar_last", 64'({r_w[1], g_w[1], b_w[1]}), 64'h000000);
            end
            if (lat[2] == 2'd0 && de_w[2] && x_w[2] >= 12'd640)
                cmp("bar_leftover", 64'({r_w[2], g_w[2], b_w[2]}), 64'h000000);
            if (lat[0] == 2'd3 && de_w[0] && frames0 == 3 && x_w[0] == 12'd5 && y_w[0] == 12'd3)
                cmp("gradient_f3", 64'({r_w[0], g_w[0], b_w[0]}), 64'h050302);
        end
        prev_rst = rst;
        prev_hs1 = hs_w[1];
        prev_vs0 = vs_w[0];
        mcyc++;
    end

endmodule
